// File: rtl/queue_pkg.sv
// Shared types and constants for the queue dispatcher and its FIFO.
// Imported by the dispatcher top level.
package queue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE
    } disp_state_e;

    // Ticket 0 is reserved: the counter reads dn == 0 as "idle".
    localparam int unsigned TICKET_FIRST = 1;

endpackage

// File: rtl/queue_dispatcher_if.sv
// Bus between the queue dispatcher and its environment: arrivals in, counter load out,
// counter busy back in, plus occupancy status.
interface queue_dispatcher_if #(
    parameter int unsigned NUM_W  = 4,
    parameter int unsigned TIME_W = 4,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              enq;
    logic [TIME_W-1:0] svc_time;
    logic              busy;
    logic              enq_ack;
    logic              enq_rej;
    logic [NUM_W-1:0]  ticket_out;
    logic              ld;
    logic [NUM_W-1:0]  dn_out;
    logic [TIME_W-1:0] dt_out;
    logic [AW:0]       count;
    logic              full;
    logic              empty;

    // Dispatcher side.
    modport slave (
        input  enq,
        input  svc_time,
        input  busy,
        output enq_ack,
        output enq_rej,
        output ticket_out,
        output ld,
        output dn_out,
        output dt_out,
        output count,
        output full,
        output empty
    );

    // Arrival source / counter side.
    modport master (
        output enq,
        output svc_time,
        output busy,
        input  enq_ack,
        input  enq_rej,
        input  ticket_out,
        input  ld,
        input  dn_out,
        input  dt_out,
        input  count,
        input  full,
        input  empty
    );

endinterface

// File: rtl/queue_fifo.sv
// Circular synchronous FIFO with registered occupancy count; full/empty derive from the count,
// so pointers are free to wrap mod DEPTH. Push at full and pop at empty are ignored.
module queue_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reset clears the pointers and count, which drops all entries.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/queue_dispatcher.sv
// Ticketing front end of the service counter: numbers arrivals, queues them, and loads the
// head entry into the counter with a one-cycle ld pulse whenever the counter is idle.
module queue_dispatcher
    import queue_pkg::*;
#(
    parameter int unsigned NUM_W  = 4,
    parameter int unsigned TIME_W = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    queue_dispatcher_if.slave io_bus
);

    localparam int unsigned      AW          = $clog2(DEPTH);
    localparam int unsigned      W           = NUM_W + TIME_W;
    localparam logic [NUM_W-1:0] TICKET_INIT = NUM_W'(TICKET_FIRST);
    localparam logic [NUM_W-1:0] TICKET_LAST = '1;

    disp_state_e       r_state;
    disp_state_e       w_state_next;

    logic [NUM_W-1:0]  r_next_ticket;
    logic              r_enq_ack;
    logic              r_enq_rej;
    logic [NUM_W-1:0]  r_ticket_out;

    logic              r_ld;
    logic [NUM_W-1:0]  r_dn_out;
    logic [TIME_W-1:0] r_dt_out;
    logic              w_ld_next;
    logic [NUM_W-1:0]  w_dn_next;
    logic [TIME_W-1:0] w_dt_next;

    logic              w_push;
    logic              w_pop;
    logic [TIME_W-1:0] w_svc_clamped;
    logic [W-1:0]      w_wdata;
    logic [W-1:0]      w_rdata;
    logic [AW:0]       w_count;
    logic              w_full;
    logic              w_empty;

    // Full is judged on the registered count, so a same-edge pop never rescues an arrival.
    assign w_push        = io_bus.enq && !w_full;
    // The counter treats a zero service time as meaningless; serve such arrivals for 1 cycle.
    assign w_svc_clamped = (io_bus.svc_time == '0) ? TIME_W'(1) : io_bus.svc_time;
    assign w_wdata       = {r_next_ticket, w_svc_clamped};

    queue_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_next_ticket <= TICKET_INIT;
            r_enq_ack     <= 1'b0;
            r_enq_rej     <= 1'b0;
            r_ticket_out  <= '0;
        end else begin
            r_enq_ack    <= w_push;
            r_enq_rej    <= io_bus.enq && w_full;
            r_ticket_out <= w_push ? r_next_ticket : '0;
            if (w_push) begin
                r_next_ticket <= (r_next_ticket == TICKET_LAST) ? TICKET_INIT
                                                                : r_next_ticket + NUM_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_ld     <= 1'b0;
            r_dn_out <= '0;
            r_dt_out <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ld     <= w_ld_next;
            r_dn_out <= w_dn_next;
            r_dt_out <= w_dt_next;
        end
    end

    // WAIT_ACK covers the cycle after ld, when the counter has not yet raised busy.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_ld_next    = 1'b0;
        w_dn_next    = '0;
        w_dt_next    = '0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty && !io_bus.busy) begin
                    w_state_next           = LOAD;
                    w_pop                  = 1'b1;
                    w_ld_next              = 1'b1;
                    {w_dn_next, w_dt_next} = w_rdata;
                end
            end
            LOAD:      w_state_next = WAIT_ACK;
            WAIT_ACK:  if (io_bus.busy) w_state_next = WAIT_DONE;
            WAIT_DONE: if (!io_bus.busy) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    assign io_bus.enq_ack    = r_enq_ack;
    assign io_bus.enq_rej    = r_enq_rej;
    assign io_bus.ticket_out = r_ticket_out;
    assign io_bus.ld         = r_ld;
    assign io_bus.dn_out     = r_dn_out;
    assign io_bus.dt_out     = r_dt_out;
    assign io_bus.count      = w_count;
    assign io_bus.full       = w_full;
    assign io_bus.empty      = w_empty;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Bench for queue_dispatcher: a behavioural service counter closes the busy loop, and a
// negedge monitor checks acks and loads against scoreboard queues filled by the driver.
module tb_queue_dispatcher;

    localparam int unsigned NUM_W  = 4;
    localparam int unsigned TIME_W = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int          TMAX   = (1 << NUM_W) - 1;

    typedef struct {
        bit rej;
        int ticket;
    } ack_t;

    typedef struct {
        int dn;
        int dt;
    } ld_t;

    typedef struct {
        int svc;
        int exp_dt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic [TIME_W-1:0] rem;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int exp_ticket = 1;
    bit mon_en = 1'b0;
    logic prev_ld = 1'b0;
    logic prev_busy = 1'b0;

    ack_t ack_q[$];
    ld_t  ld_q[$];
    ack_t m_ack;
    ld_t  m_ld;

    always #5 clk = ~clk;

    queue_dispatcher_if #(.NUM_W(NUM_W), .TIME_W(TIME_W), .DEPTH(DEPTH)) q_if ();

    queue_dispatcher #(.NUM_W(NUM_W), .TIME_W(TIME_W), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (q_if)
    );

    // Service counter: busy from the cycle after ld, for dt_out cycles; hold forces busy.
    always @(posedge clk) begin
        if (rst) rem <= '0;
        else if (q_if.ld) rem <= q_if.dt_out;
        else if (rem != '0) rem <= rem - 1'b1;
    end
    assign q_if.busy = hold || (rem != '0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (q_if.enq_ack || q_if.enq_rej) begin
                if (ack_q.size() == 0) begin
                    check("spurious_ack", int'(q_if.enq_ack || q_if.enq_rej), 0);
                end else begin
                    m_ack = ack_q.pop_front();
                    check("ack_is_rej", int'(q_if.enq_rej), int'(m_ack.rej));
                    check("ack_is_ack", int'(q_if.enq_ack), int'(!m_ack.rej));
                    if (!m_ack.rej) check("ticket_out", int'(q_if.ticket_out), m_ack.ticket);
                end
            end
            if (q_if.ld) begin
                check("ld_dn_nonzero", int'(q_if.dn_out != '0), 1);
                check("ld_while_busy_or_after_ld", int'(prev_ld || q_if.busy), 0);
                if (ld_q.size() == 0) begin
                    check("spurious_ld", int'(q_if.ld), 0);
                end else begin
                    m_ld = ld_q.pop_front();
                    check("ld_dn_out", int'(q_if.dn_out), m_ld.dn);
                    check("ld_dt_out", int'(q_if.dt_out), m_ld.dt);
                end
            end else begin
                check("dn_dt_zero_without_ld", int'({q_if.dn_out, q_if.dt_out}), 0);
            end
        end
        if (prev_busy && !q_if.busy) fall_cyc = cyc;
        prev_ld   = q_if.ld;
        prev_busy = q_if.busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one arrival for one edge and record what the dispatcher must answer.
    task automatic enq_one(input int svc, input bit accept);
        q_if.enq      = 1'b1;
        q_if.svc_time = TIME_W'(svc);
        if (accept) begin
            ack_q.push_back('{rej: 1'b0, ticket: exp_ticket});
            ld_q.push_back('{dn: exp_ticket, dt: (svc == 0) ? 1 : svc});
            exp_ticket = (exp_ticket == TMAX) ? 1 : exp_ticket + 1;
        end else begin
            ack_q.push_back('{rej: 1'b1, ticket: 0});
        end
        tick();
        q_if.enq = 1'b0;
    endtask

    task automatic wait_ld(output int c);
        bit found;
        found = 1'b0;
        c = -1;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (q_if.ld) begin
                found = 1'b1;
                c = cyc;
            end
        end
        if (!found) check("ld_timeout", int'(found), 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            if (ld_q.size() == 0 && ack_q.size() == 0 && !q_if.busy && q_if.empty && !q_if.ld)
                done = 1'b1;
        end
        if (!done) check("drain_timeout", int'(done), 1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        hold = 1'b0;
        q_if.enq = 1'b0;
        ack_q.delete();
        ld_q.delete();
        tick();
        tick();
        rst = 1'b0;
        exp_ticket = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   c_ld;
        int   n_busy;

        vt = '{'{svc: 0, exp_dt: 1}, '{svc: 1, exp_dt: 1}, '{svc: 7, exp_dt: 7},
               '{svc: 15, exp_dt: 15}, '{svc: 0, exp_dt: 1}};

        q_if.enq      = 1'b0;
        q_if.svc_time = '0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_count", int'(q_if.count), 0);
        check("rst_empty", int'(q_if.empty), 1);
        check("rst_full", int'(q_if.full), 0);
        check("rst_ld", int'(q_if.ld), 0);
        check("rst_enq_ack", int'(q_if.enq_ack), 0);
        check("rst_enq_rej", int'(q_if.enq_rej), 0);
        check("rst_ticket_out", int'(q_if.ticket_out), 0);
        check("rst_dn_dt", int'({q_if.dn_out, q_if.dt_out}), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // First-arrival latency, then back-to-back service spacing.
        enq_one(3, 1'b1);
        check("lat_count_cycle1", int'(q_if.count), 1);
        check("lat_no_ld_cycle1", int'(q_if.ld), 0);
        enq_one(2, 1'b1);
        check("lat_ld_cycle2", int'(q_if.ld), 1);
        check("push_pop_count", int'(q_if.count), 1);
        wait_ld(c_ld);
        check("b2b_ld_after_fall", c_ld - fall_cyc, 2);
        drain();

        // Fill to full with the counter held busy; a rejected arrival costs no ticket.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) enq_one(i + 1, 1'b1);
        check("full_count", int'(q_if.count), 8);
        check("full_flag", int'(q_if.full), 1);
        check("full_not_empty", int'(q_if.empty), 0);
        hold = 1'b0;
        enq_one(9, 1'b0);
        check("rej_with_pop_count", int'(q_if.count), 7);
        check("rej_with_pop_full", int'(q_if.full), 0);
        drain();

        // Service-time clamp: zero becomes one cycle of service.
        for (int i = 0; i < 5; i++) begin
            enq_one(vt[i].svc, 1'b1);
            wait_ld(c_ld);
            check("clamp_dt_out", int'(q_if.dt_out), vt[i].exp_dt);
            n_busy = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (q_if.busy) n_busy++;
                else if (n_busy > 0) break;
            end
            check("busy_len", n_busy, vt[i].exp_dt);
        end
        drain();

        // Ticket wrap: 1..15 then 1.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            enq_one(1, 1'b1);
            check("wrap_ticket", int'(q_if.ticket_out), (i == 15) ? 1 : i + 1);
            drain();
        end

        // Simultaneous push and pop at count 3, with wrapped pointers.
        hold = 1'b1;
        enq_one(2, 1'b1);
        enq_one(3, 1'b1);
        enq_one(4, 1'b1);
        check("pre_pushpop_count", int'(q_if.count), 3);
        hold = 1'b0;
        enq_one(5, 1'b1);
        check("pushpop_count", int'(q_if.count), 3);
        drain();

        // Reset while serving with 4 queued.
        enq_one(15, 1'b1);
        wait_ld(c_ld);
        for (int i = 0; i < 4; i++) enq_one(1, 1'b1);
        tick();
        check("prerst_count", int'(q_if.count), 4);
        check("prerst_busy", int'(q_if.busy), 1);
        rst = 1'b1;
        ack_q.delete();
        ld_q.delete();
        tick();
        check("midrst_count", int'(q_if.count), 0);
        check("midrst_empty", int'(q_if.empty), 1);
        check("midrst_ld", int'(q_if.ld), 0);
        check("midrst_full", int'(q_if.full), 0);
        rst = 1'b0;
        exp_ticket = 1;
        repeat (5) tick();
        enq_one(2, 1'b1);
        check("ticket_after_rst", int'(q_if.ticket_out), 1);
        drain();

        check("ack_queue_left", ack_q.size(), 0);
        check("ld_queue_left", ld_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
